// File: rtl/onehot_reg_bank_pkg.sv
// Shared constants and helpers for the one-hot register bank and
// related blocks that consume address-decoder outputs.
package onehot_reg_bank_pkg;

    localparam int DEF_LEN     = 2;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_RST_VAL = 0;

    // Bank depth for a given address width.
    function automatic int nreg(input int len);
        return 1 << len;
    endfunction

    // Largest value of the (len+1)-bit accepted-write counter.
    function automatic int wrcount_max(input int len);
        return (1 << (len + 1)) - 1;
    endfunction

endpackage

// File: rtl/onehot_reg_bank_onehot_checker.sv
// Combinational check that a select vector has exactly one bit set.
module onehot_checker #(
    parameter int N = 4
) (
    input  logic [N-1:0] Vec,
    output logic         Valid
);

    // Non-zero and clearing the lowest set bit leaves nothing behind.
    assign Valid = (Vec != '0) && ((Vec & (Vec - 1'b1)) == '0);

endmodule

// File: rtl/onehot_reg_bank.sv
// Register bank written through a one-hot decoder select, with two
// registered read ports, write-to-read bypass and a sticky select error.
module onehot_reg_bank
    import onehot_reg_bank_pkg::*;
#(
    parameter int               LEN     = DEF_LEN,
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                WrEn,
    input  logic [2**LEN-1:0]   WrSel,
    input  logic [WIDTH-1:0]    WrData,
    input  logic                RdEnA,
    input  logic [LEN-1:0]      RdAddrA,
    input  logic                RdEnB,
    input  logic [LEN-1:0]      RdAddrB,
    output logic [WIDTH-1:0]    RdDataA,
    output logic                RdValidA,
    output logic [WIDTH-1:0]    RdDataB,
    output logic                RdValidB,
    output logic                SelErr,
    input  logic                ErrClr,
    output logic [LEN:0]        WrCount
);

    localparam int              NREG    = nreg(LEN);
    localparam int              CNT_W   = LEN + 1;
    localparam logic [LEN:0]    CNT_MAX = CNT_W'(wrcount_max(LEN));

    logic [WIDTH-1:0] regs [NREG];
    logic             sel_onehot;
    logic             wr_ok;
    logic             wr_bad;
    logic [WIDTH-1:0] rd_next_a;
    logic [WIDTH-1:0] rd_next_b;

    onehot_checker #(.N(NREG)) u_sel_check (
        .Vec   (WrSel),
        .Valid (sel_onehot)
    );

    assign wr_ok  = WrEn && sel_onehot;
    assign wr_bad = WrEn && !sel_onehot;

    // Read handshake: RdEnX is a request with no back-pressure; RdValidX is
    // high for exactly the cycle after the request, while RdDataX carries it.
    always_comb begin
        rd_next_a = regs[RdAddrA];
        rd_next_b = regs[RdAddrB];
        if (wr_ok && WrSel[RdAddrA]) rd_next_a = WrData;
        if (wr_ok && WrSel[RdAddrB]) rd_next_b = WrData;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_ok && WrSel[i]) regs[i] <= WrData;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            RdDataA  <= '0;
            RdValidA <= 1'b0;
            RdDataB  <= '0;
            RdValidB <= 1'b0;
        end else begin
            RdValidA <= RdEnA;
            RdValidB <= RdEnB;
            if (RdEnA) RdDataA <= rd_next_a;
            if (RdEnB) RdDataB <= rd_next_b;
        end
    end

    // A fault in the same cycle as a clear must stay visible.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            SelErr  <= 1'b0;
            WrCount <= '0;
        end else begin
            if (wr_bad)      SelErr <= 1'b1;
            else if (ErrClr) SelErr <= 1'b0;
            if (wr_ok && WrCount != CNT_MAX) WrCount <= WrCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_onehot_reg_bank.sv
// Randomised and directed bench for onehot_reg_bank (LEN=2, WIDTH=8).
module tb_onehot_reg_bank;

    logic       Clk;
    logic       Rst;
    logic       WrEn;
    logic [3:0] WrSel;
    logic [7:0] WrData;
    logic       RdEnA;
    logic [1:0] RdAddrA;
    logic       RdEnB;
    logic [1:0] RdAddrB;
    logic [7:0] RdDataA;
    logic       RdValidA;
    logic [7:0] RdDataB;
    logic       RdValidB;
    logic       SelErr;
    logic       ErrClr;
    logic [2:0] WrCount;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_regs [4];
    logic [7:0] m_rda, m_rdb;
    logic       m_va, m_vb, m_err;
    int         m_cnt;

    onehot_reg_bank #(.LEN(2), .WIDTH(8), .RST_VAL(8'h00)) dut (
        .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrSel(WrSel), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
        .RdDataA(RdDataA), .RdValidA(RdValidA), .RdDataB(RdDataB),
        .RdValidB(RdValidB), .SelErr(SelErr), .ErrClr(ErrClr), .WrCount(WrCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drive one cycle of inputs, advance the model, and land #1 after the edge.
    task automatic step(input logic rst, input logic we, input logic [3:0] sel,
                        input logic [7:0] data, input logic rea, input logic [1:0] aa,
                        input logic reb, input logic [1:0] ab, input logic clr);
        logic [7:0] after_wr [4];
        logic       ok;
        Rst = rst; WrEn = we; WrSel = sel; WrData = data;
        RdEnA = rea; RdAddrA = aa; RdEnB = reb; RdAddrB = ab; ErrClr = clr;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_rda = 8'h00; m_rdb = 8'h00; m_va = 0; m_vb = 0; m_err = 0; m_cnt = 0;
        end else begin
            ok = we && ($countones(sel) == 1);
            after_wr = m_regs;
            for (int i = 0; i < 4; i++) if (ok && sel == (4'b0001 << i)) after_wr[i] = data;
            if (rea) m_rda = after_wr[aa];
            if (reb) m_rdb = after_wr[ab];
            m_va = rea;
            m_vb = reb;
            if (we && !ok) m_err = 1;
            else if (clr) m_err = 0;
            if (ok) m_cnt = (m_cnt + 1 > 7) ? 7 : m_cnt + 1;
            m_regs = after_wr;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 4'b0000, 8'h00, 0, 2'd0, 0, 2'd0, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 4'b0000, 8'h00, 0, 2'd0, 0, 2'd0, 0);
        checks += 4;
        if (RdDataA !== 8'h00 || RdValidA !== 1'b0) begin
            errors++; $display("FAIL reset_a: data=%h valid=%b need 00/0", RdDataA, RdValidA);
        end
        if (RdDataB !== 8'h00 || RdValidB !== 1'b0) begin
            errors++; $display("FAIL reset_b: data=%h valid=%b need 00/0", RdDataB, RdValidB);
        end
        if (SelErr !== 1'b0) begin
            errors++; $display("FAIL reset_selerr: got %b need 0", SelErr);
        end
        if (WrCount !== 3'd0) begin
            errors++; $display("FAIL reset_wrcount: got %0d need 0", WrCount);
        end
        for (int a = 0; a < 4; a++) begin
            step(0, 0, 4'b0000, 8'h00, 1, 2'(a), 1, 2'(3 - a), 0);
            checks += 2;
            if (RdDataA !== 8'h00 || RdValidA !== 1'b1) begin
                errors++; $display("FAIL reset_read_a%0d: data=%h valid=%b need 00/1", a, RdDataA, RdValidA);
            end
            if (RdDataB !== 8'h00 || RdValidB !== 1'b1) begin
                errors++; $display("FAIL reset_read_b%0d: data=%h valid=%b need 00/1", a, RdDataB, RdValidB);
            end
        end
        idle();
        checks++;
        if (RdValidA !== 1'b0 || RdValidB !== 1'b0) begin
            errors++; $display("FAIL valid_pulse: a=%b b=%b need 0/0", RdValidA, RdValidB);
        end
    endtask

    task automatic test_write_read();
        step(0, 1, 4'b0100, 8'hA5, 0, 2'd0, 0, 2'd0, 0);
        checks++;
        if (WrCount !== 3'd1) begin
            errors++; $display("FAIL wr_count1: got %0d need 1", WrCount);
        end
        step(0, 0, 4'b0000, 8'h00, 1, 2'd2, 0, 2'd0, 0);
        checks++;
        if (RdDataA !== 8'hA5 || RdValidA !== 1'b1) begin
            errors++; $display("FAIL wr_read2: data=%h valid=%b need a5/1", RdDataA, RdValidA);
        end
        idle();
        checks++;
        if (RdDataA !== 8'hA5 || RdValidA !== 1'b0) begin
            errors++; $display("FAIL rd_hold: data=%h valid=%b need a5/0", RdDataA, RdValidA);
        end
        for (int a = 0; a < 4; a++) begin
            if (a == 2) continue;
            step(0, 0, 4'b0000, 8'h00, 1, 2'(a), 1, 2'(a), 0);
            checks++;
            if (RdDataA !== 8'h00 || RdDataB !== 8'h00) begin
                errors++; $display("FAIL wr_other%0d: a=%h b=%h need 00", a, RdDataA, RdDataB);
            end
        end
    endtask

    task automatic test_invalid_sel();
        logic [3:0] bad_sel [2];
        bad_sel[0] = 4'b0110;
        bad_sel[1] = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            step(0, 1, bad_sel[k], 8'hFF, 0, 2'd0, 0, 2'd0, 0);
            checks += 2;
            if (SelErr !== 1'b1) begin
                errors++; $display("FAIL bad_sel_err%0d: got %b need 1", k, SelErr);
            end
            if (WrCount !== 3'd1) begin
                errors++; $display("FAIL bad_sel_cnt%0d: got %0d need 1", k, WrCount);
            end
        end
        for (int a = 0; a < 4; a++) begin
            step(0, 0, 4'b0000, 8'h00, 1, 2'(a), 0, 2'd0, 0);
            checks++;
            if (RdDataA !== ((a == 2) ? 8'hA5 : 8'h00)) begin
                errors++; $display("FAIL bad_sel_keep%0d: got %h need %h", a, RdDataA, m_rda);
            end
        end
        step(0, 0, 4'b1111, 8'h77, 0, 2'd0, 0, 2'd0, 1);
        checks++;
        if (SelErr !== 1'b0) begin
            errors++; $display("FAIL err_clr: got %b need 0", SelErr);
        end
        step(0, 0, 4'b1011, 8'h77, 0, 2'd0, 0, 2'd0, 0);
        checks++;
        if (SelErr !== 1'b0 || WrCount !== 3'd1) begin
            errors++; $display("FAIL wren0_garbage: err=%b cnt=%0d need 0/1", SelErr, WrCount);
        end
    endtask

    task automatic test_bypass();
        step(0, 1, 4'b0001, 8'h3C, 1, 2'd0, 1, 2'd0, 0);
        checks += 2;
        if (RdDataA !== 8'h3C || RdValidA !== 1'b1) begin
            errors++; $display("FAIL bypass_a: data=%h valid=%b need 3c/1", RdDataA, RdValidA);
        end
        if (RdDataB !== 8'h3C || RdValidB !== 1'b1) begin
            errors++; $display("FAIL bypass_b: data=%h valid=%b need 3c/1", RdDataB, RdValidB);
        end
    endtask

    task automatic test_saturation();
        int sel_i;
        for (int k = 0; k < 9; k++) begin
            sel_i = $urandom_range(0, 3);
            step(0, 1, 4'(1 << sel_i), 8'($urandom), 0, 2'd0, 0, 2'd0, 0);
            checks++;
            if (WrCount !== 3'(m_cnt)) begin
                errors++; $display("FAIL sat_step%0d: got %0d need %0d", k, WrCount, m_cnt);
            end
        end
        checks++;
        if (WrCount !== 3'd7) begin
            errors++; $display("FAIL sat_final: got %0d need 7", WrCount);
        end
        step(0, 1, 4'b0011, 8'h55, 0, 2'd0, 0, 2'd0, 1);
        checks++;
        if (SelErr !== 1'b1 || WrCount !== 3'd7) begin
            errors++; $display("FAIL set_wins: err=%b cnt=%0d need 1/7", SelErr, WrCount);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 4'b1000, 8'h11, 0, 2'd0, 0, 2'd0, 0);
        step(1, 1, 4'b1000, 8'h22, 1, 2'd3, 1, 2'd3, 0);
        checks += 2;
        if (RdValidA !== 1'b0 || RdDataA !== 8'h00 || RdValidB !== 1'b0) begin
            errors++; $display("FAIL rst_mid_rd: data=%h valid=%b/%b need 00/0/0", RdDataA, RdValidA, RdValidB);
        end
        if (WrCount !== 3'd0 || SelErr !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state: cnt=%0d err=%b need 0/0", WrCount, SelErr);
        end
        step(0, 0, 4'b0000, 8'h00, 1, 2'd3, 0, 2'd0, 0);
        checks++;
        if (RdDataA !== 8'h00) begin
            errors++; $display("FAIL rst_mid_reg3: got %h need 00", RdDataA);
        end
    endtask

    task automatic test_random();
        logic [3:0] sel;
        for (int k = 0; k < 400; k++) begin
            sel = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            step(($urandom_range(0, 59) == 0), 1'($urandom), sel, 8'($urandom),
                 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                 ($urandom_range(0, 7) == 0));
            checks++;
            if (RdDataA !== m_rda || RdValidA !== m_va || RdDataB !== m_rdb ||
                RdValidB !== m_vb || SelErr !== m_err || WrCount !== 3'(m_cnt)) begin
                errors++;
                $display("FAIL random%0d: a=%h/%b b=%h/%b err=%b cnt=%0d need a=%h/%b b=%h/%b err=%b cnt=%0d",
                         k, RdDataA, RdValidA, RdDataB, RdValidB, SelErr, WrCount,
                         m_rda, m_va, m_rdb, m_vb, m_err, m_cnt);
            end
        end
    endtask

    initial begin
        Rst = 1; WrEn = 0; WrSel = '0; WrData = '0; RdEnA = 0; RdAddrA = '0;
        RdEnB = 0; RdAddrB = '0; ErrClr = 0;
        test_reset();
        test_write_read();
        test_invalid_sel();
        test_bypass();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
